mapper_regfile: RTL and testbench
=================================

// Module: mapper_regfile
// PURPOSE
//  Clocked, parametrised control/trap register file for the MegaMapper CPLD.
//  Holds CTRL_COUNT mapper control registers written from the Z80 bus, and records
//  recent M1 opcode fetches in a HIST_DEPTH FIFO that the trap handler drains.
//  Keeps a sticky I/O-violation flag with an overflow flag, and sits between the
//  address decoder (reg_cs/reg_sel) and the mapper datapath (ctrl_out).
// PARAMETERS
//  CTRL_COUNT  4  number of control registers (1..6)
//  CTRL_WIDTH  4  bits per control register (1..8), taken from data_in[CTRL_WIDTH-1:0]
//  HIST_DEPTH  4  opcode history FIFO depth, power of two (2..16)
//  SEL_W       3  width of reg_sel; 2**SEL_W >= CTRL_COUNT+2
// PORTS
//  clk            in   1                      system clock; all state updates on rising edge
//  reset_n        in   1                      reset, asynchronous, active-low
//  wr_n           in   1                      Z80 write strobe, already synchronised to clk
//  rd_n           in   1                      Z80 read strobe, already synchronised to clk
//  m1_n           in   1                      Z80 M1, already synchronised to clk
//  data_in        in   8                      Z80 data bus input
//  reg_cs         in   1                      decoder hit on the register window
//  reg_sel        in   SEL_W                  register index within window
//  record_en      in   1                      enable opcode capture
//  io_violation   in   1                      violation pulse from I/O guard (>=1 clk)
//  data_out       out  8                      read data
//  data_oe        out  1                      drive data bus
//  ctrl_out       out  CTRL_COUNT*CTRL_WIDTH  control regs, reg k at [k*CTRL_WIDTH +: CTRL_WIDTH]
//  hist_count     out  $clog2(HIST_DEPTH)+1   FIFO occupancy
//  trap_pending   out  1                      = violation sticky flag
// BEHAVIOUR
//  - Reset (async): ctrl regs=0, FIFO empty (pointers 0, count 0), violation=0, overflow=0,
//    opcode latch=0, strobe history regs=1. Outputs: ctrl_out=0, hist_count=0, trap_pending=0,
//    data_oe=0. Reset mid-access aborts the access, with no partial write or pop.
//  - Edge detect: x_rise = x_prev==0 && x==1, where x_prev is registered each clk. All
//    actions fire on the clk of the rising edge, so state updates 1 clk after strobe deassert.
//  - Register map (reg_sel): 0..CTRL_COUNT-1 = control regs; CTRL_COUNT = HIST pop port;
//    CTRL_COUNT+1 = STATUS. Higher selects: writes ignored, reads return 8'hFF.
//  - Write: wr_rise && reg_cs. Control reg k <= data_in[CTRL_WIDTH-1:0]. Writing HIST is
//    ignored. STATUS write: bit7=1 clears violation+overflow; bit6=1 flushes FIFO.
//  - Read: data_oe = reg_cs && !rd_n (combinational). Control reg reads are zero-extended.
//    HIST returns the oldest entry, or 8'h00 if empty. STATUS = {violation, overflow,
//    1'b0, count[4:0] zero-extended}.
//  - Pop: rd_rise && reg_cs && sel==HIST && count!=0; data stays stable for the whole read.
//  - Capture: each clk with !m1_n && !rd_n, opcode latch <= data_in. Push latch on
//    m1_rise && record_en. M1 without a read (interrupt ack) does not update the latch.
//  - Full push without a pop: overwrite the oldest (advance both pointers), count stays
//    HIST_DEPTH, overflow <= 1.
//  - Push+pop same clk: both occur, count unchanged, no overflow even if full. Pop on empty
//    is a no-op. Pointers wrap modulo HIST_DEPTH.
//  - Flush: pointers and count go to 0. Flush+push same clk: flush wins, the push is lost.
//  - Violation: io_violation==1 sets violation each clk. Set beats a simultaneous STATUS clear.
//  - No combinational path from data_in to ctrl_out; ctrl_out changes only on clk.
// TESTING
//  1) Reset, write 8'hA5 to sel 1 (CTRL_WIDTH=4) -> ctrl_out[7:4]=4'h5 one clk after
//     wr_n rise; other fields 0; read sel 1 -> 8'h05.
//  2) record_en=1, fetch opcodes 8'h3E,8'hD3,8'hED -> hist_count=3; three HIST reads
//     return 3E,D3,ED; a 4th read returns 00; count=0.
//  3) Six fetches (11..16, DEPTH 4) -> count=4, STATUS[6]=1, pops return 13,14,15,16.
//  4) Full FIFO, pop rd_n rise coincident with m1_n rise -> count stays 4, overflow not set.
//  5) Pulse io_violation 1 clk -> trap_pending=1; STATUS write 8'h80 in the same clk
//     as a second pulse -> still 1; later write 8'h80 -> 0.
//  6) Assert reset_n=0 mid-write (wr_n low) -> no write on wr_n rise after release; all outputs 0.

Source files
------------

// File: rtl/mapper_regfile.sv
// MegaMapper control/trap register file: mapper control registers, an M1 opcode
// history FIFO for the trap handler, and sticky I/O-violation/overflow status.
module mapper_regfile #(
    parameter int unsigned CTRL_COUNT = 4,
    parameter int unsigned CTRL_WIDTH = 4,
    parameter int unsigned HIST_DEPTH = 4,
    parameter int unsigned SEL_W      = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wr_n,
    input  logic                             rd_n,
    input  logic                             m1_n,
    input  logic [7:0]                       data_in,
    input  logic                             reg_cs,
    input  logic [SEL_W-1:0]                 reg_sel,
    input  logic                             record_en,
    input  logic                             io_violation,
    output logic [7:0]                       data_out,
    output logic                             data_oe,
    output logic [CTRL_COUNT*CTRL_WIDTH-1:0] ctrl_out,
    output logic [$clog2(HIST_DEPTH):0]      hist_count,
    output logic                             trap_pending
);
    localparam int unsigned PTR_W = $clog2(HIST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [SEL_W-1:0] SEL_HIST   = SEL_W'(CTRL_COUNT);
    localparam logic [SEL_W-1:0] SEL_STATUS = SEL_W'(CTRL_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(HIST_DEPTH);

    logic [CTRL_WIDTH-1:0] ctrl_q [CTRL_COUNT];
    logic [CTRL_WIDTH-1:0] ctrl_d [CTRL_COUNT];
    logic [7:0]            hist_q [HIST_DEPTH];
    logic [7:0]            hist_d [HIST_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  viol_q, viol_d, ovf_q, ovf_d;
    logic [7:0]            opcode_q, opcode_d;
    logic                  wr_prev_q, rd_prev_q, m1_prev_q;
    logic [2:0]            arm_q, arm_d;
    logic                  wr_rise, rd_rise, m1_rise;
    logic                  wr_hit, push, pop, flush;

    // A strobe held low across reset is disarmed until seen high, so the access aborts.
    assign arm_d   = arm_q | {m1_n, rd_n, wr_n};
    assign wr_rise = arm_q[0] && !wr_prev_q && wr_n;
    assign rd_rise = arm_q[1] && !rd_prev_q && rd_n;
    assign m1_rise = arm_q[2] && !m1_prev_q && m1_n;

    assign wr_hit = wr_rise && reg_cs;
    assign flush  = wr_hit && (reg_sel == SEL_STATUS) && data_in[6];
    assign push   = m1_rise && record_en;
    assign pop    = rd_rise && reg_cs && (reg_sel == SEL_HIST) && (count_q != '0);

    assign data_oe      = reg_cs && !rd_n;
    assign hist_count   = count_q;
    assign trap_pending = viol_q;

    for (genvar g = 0; g < CTRL_COUNT; g++) begin : g_ctrl_out
        assign ctrl_out[g*CTRL_WIDTH +: CTRL_WIDTH] = ctrl_q[g];
    end

    // Read mux
    always_comb begin
        data_out = 8'hFF;
        for (int unsigned k = 0; k < CTRL_COUNT; k++) begin
            if (reg_sel == SEL_W'(k)) data_out = 8'(ctrl_q[k]);
        end
        if (reg_sel == SEL_HIST)   data_out = (count_q != '0) ? hist_q[rd_ptr_q] : 8'h00;
        if (reg_sel == SEL_STATUS) data_out = {viol_q, ovf_q, 1'b0, 5'(count_q)};
    end

    // Next-state for control registers, FIFO and status flags
    always_comb begin
        ctrl_d   = ctrl_q;
        hist_d   = hist_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        viol_d   = viol_q;
        ovf_d    = ovf_q;
        opcode_d = opcode_q;

        for (int unsigned k = 0; k < CTRL_COUNT; k++) begin
            if (wr_hit && reg_sel == SEL_W'(k)) ctrl_d[k] = data_in[CTRL_WIDTH-1:0];
        end

        if (!m1_n && !rd_n) opcode_d = data_in;

        if (wr_hit && reg_sel == SEL_STATUS && data_in[7]) begin
            viol_d = 1'b0;
            ovf_d  = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (push) begin
            hist_d[wr_ptr_q] = opcode_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else if (count_q == CNT_FULL) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                ovf_d    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end

        if (io_violation) viol_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < CTRL_COUNT; k++) ctrl_q[k] <= '0;
            for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            viol_q    <= 1'b0;
            ovf_q     <= 1'b0;
            opcode_q  <= '0;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            m1_prev_q <= 1'b1;
            arm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            hist_q    <= hist_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            viol_q    <= viol_d;
            ovf_q     <= ovf_d;
            opcode_q  <= opcode_d;
            wr_prev_q <= wr_n;
            rd_prev_q <= rd_n;
            m1_prev_q <= m1_n;
            arm_q     <= arm_d;
        end
    end
endmodule

// File: tb/tb_mapper_regfile.sv
// Directed bench for mapper_regfile (CTRL_COUNT=4, CTRL_WIDTH=4, HIST_DEPTH=4, SEL_W=3).
module tb_mapper_regfile;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_n, rd_n, m1_n;
    logic [7:0]  data_in;
    logic        reg_cs;
    logic [2:0]  reg_sel;
    logic        record_en;
    logic        io_violation;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [15:0] ctrl_out;
    logic [2:0]  hist_count;
    logic        trap_pending;

    int vectors = 0;
    int miscompares = 0;

    mapper_regfile #(.CTRL_COUNT(4), .CTRL_WIDTH(4), .HIST_DEPTH(4), .SEL_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_n(wr_n), .rd_n(rd_n), .m1_n(m1_n),
        .data_in(data_in), .reg_cs(reg_cs), .reg_sel(reg_sel), .record_en(record_en),
        .io_violation(io_violation), .data_out(data_out), .data_oe(data_oe),
        .ctrl_out(ctrl_out), .hist_count(hist_count), .trap_pending(trap_pending)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_write(input logic [2:0] sel, input logic [7:0] d);
        @(negedge clk); reg_cs = 1'b1; reg_sel = sel; data_in = d; wr_n = 1'b0;
        @(negedge clk); wr_n = 1'b1;
        @(negedge clk); reg_cs = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] sel, output logic [7:0] d, output logic oe);
        @(negedge clk); reg_cs = 1'b1; reg_sel = sel; rd_n = 1'b0;
        @(negedge clk); d = data_out; oe = data_oe;
        @(negedge clk); rd_n = 1'b1;
        @(negedge clk); reg_cs = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] op);
        @(negedge clk); m1_n = 1'b0; rd_n = 1'b0; data_in = op;
        @(negedge clk);
        @(negedge clk); m1_n = 1'b1; rd_n = 1'b1; data_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; data_in = 8'h00;
        reg_cs = 1'b0; reg_sel = 3'd0; record_en = 1'b0; io_violation = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ctrl_out, hist_count, trap_pending, data_oe} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset: ctrl=%h cnt=%0d trap=%b oe=%b, expected all 0",
                     ctrl_out, hist_count, trap_pending, data_oe);
        end
    endtask

    task automatic test_ctrl_write();
        logic [7:0] d; logic oe;
        do_write(3'd1, 8'hA5);
        vectors++;
        if (ctrl_out !== 16'h0050) begin
            miscompares++; $display("FAIL ctrl_wr1: got %h expected 0050", ctrl_out);
        end
        do_read(3'd1, d, oe);
        vectors++;
        if (d !== 8'h05 || oe !== 1'b1) begin
            miscompares++; $display("FAIL ctrl_rd1: got %h oe=%b expected 05 oe=1", d, oe);
        end
        do_write(3'd3, 8'hFF);
        vectors++;
        if (ctrl_out !== 16'hF050) begin
            miscompares++; $display("FAIL ctrl_wr3: got %h expected F050", ctrl_out);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] d; logic oe;
        do_read(3'd6, d, oe);
        vectors++;
        if (d !== 8'hFF) begin
            miscompares++; $display("FAIL rd_sel6: got %h expected FF", d);
        end
        do_write(3'd7, 8'hFF);
        do_write(3'd4, 8'h99);
        vectors++;
        if (ctrl_out !== 16'hF050 || hist_count !== 3'd0) begin
            miscompares++;
            $display("FAIL wr_ignored: ctrl=%h cnt=%0d expected F050 0", ctrl_out, hist_count);
        end
    endtask

    task automatic test_fetch_fifo();
        logic [7:0] d; logic oe;
        logic [7:0] exp_q [4] = '{8'h3E, 8'hD3, 8'hED, 8'h00};
        do_fetch(8'h77);
        vectors++;
        if (hist_count !== 3'd0) begin
            miscompares++; $display("FAIL rec_disabled: cnt=%0d expected 0", hist_count);
        end
        record_en = 1'b1;
        do_fetch(8'h3E); do_fetch(8'hD3); do_fetch(8'hED);
        vectors++;
        if (hist_count !== 3'd3) begin
            miscompares++; $display("FAIL fifo_cnt3: got %0d expected 3", hist_count);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(3'd4, d, oe);
            vectors++;
            if (d !== exp_q[i]) begin
                miscompares++; $display("FAIL hist_pop%0d: got %h expected %h", i, d, exp_q[i]);
            end
        end
        do_read(3'd5, d, oe);
        vectors++;
        if (hist_count !== 3'd0 || d !== 8'h00) begin
            miscompares++; $display("FAIL fifo_empty: cnt=%0d status=%h expected 0 00", hist_count, d);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d; logic oe;
        logic [7:0] op;
        for (int i = 0; i < 6; i++) begin
            op = 8'h11 + 8'(i);
            do_fetch(op);
        end
        do_read(3'd5, d, oe);
        vectors++;
        if (d !== 8'h44 || hist_count !== 3'd4) begin
            miscompares++; $display("FAIL ovf_status: got %h cnt=%0d expected 44 4", d, hist_count);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(3'd4, d, oe);
            op = 8'h13 + 8'(i);
            vectors++;
            if (d !== op) begin
                miscompares++; $display("FAIL ovf_pop%0d: got %h expected %h", i, d, op);
            end
        end
        do_write(3'd5, 8'h80);
        do_read(3'd5, d, oe);
        vectors++;
        if (d !== 8'h00) begin
            miscompares++; $display("FAIL ovf_clear: got %h expected 00", d);
        end
    endtask

    task automatic test_push_pop_same_clk();
        logic [7:0] d; logic oe;
        logic [7:0] exp_q [4] = '{8'h22, 8'h23, 8'h24, 8'h77};
        do_fetch(8'h21); do_fetch(8'h22); do_fetch(8'h23); do_fetch(8'h24);
        // M1 fetch that is also a HIST read: pop and push share the rising edge.
        @(negedge clk); reg_cs = 1'b1; reg_sel = 3'd4; m1_n = 1'b0; rd_n = 1'b0; data_in = 8'h77;
        @(negedge clk); d = data_out;
        @(negedge clk);
        vectors++;
        if (d !== 8'h21 || data_out !== 8'h21) begin
            miscompares++; $display("FAIL pp_read: got %h/%h expected 21", d, data_out);
        end
        m1_n = 1'b1; rd_n = 1'b1;
        @(negedge clk); reg_cs = 1'b0;
        do_read(3'd5, d, oe);
        vectors++;
        if (d !== 8'h04 || hist_count !== 3'd4) begin
            miscompares++; $display("FAIL pp_status: got %h cnt=%0d expected 04 4", d, hist_count);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(3'd4, d, oe);
            vectors++;
            if (d !== exp_q[i]) begin
                miscompares++; $display("FAIL pp_pop%0d: got %h expected %h", i, d, exp_q[i]);
            end
        end
    endtask

    task automatic test_violation();
        logic [7:0] d; logic oe;
        @(negedge clk); io_violation = 1'b1;
        @(negedge clk); io_violation = 1'b0;
        vectors++;
        if (trap_pending !== 1'b1) begin
            miscompares++; $display("FAIL viol_set: got %b expected 1", trap_pending);
        end
        @(negedge clk); reg_cs = 1'b1; reg_sel = 3'd5; data_in = 8'h80; wr_n = 1'b0;
        @(negedge clk); wr_n = 1'b1; io_violation = 1'b1;
        @(negedge clk); io_violation = 1'b0; reg_cs = 1'b0;
        vectors++;
        if (trap_pending !== 1'b1) begin
            miscompares++; $display("FAIL viol_set_beats_clr: got %b expected 1", trap_pending);
        end
        do_read(3'd5, d, oe);
        vectors++;
        if (d !== 8'h80) begin
            miscompares++; $display("FAIL viol_status: got %h expected 80", d);
        end
        do_write(3'd5, 8'h80);
        vectors++;
        if (trap_pending !== 1'b0) begin
            miscompares++; $display("FAIL viol_clear: got %b expected 0", trap_pending);
        end
    endtask

    task automatic test_flush();
        logic [7:0] d; logic oe;
        do_fetch(8'h41); do_fetch(8'h42);
        do_write(3'd5, 8'h40);
        do_read(3'd4, d, oe);
        vectors++;
        if (hist_count !== 3'd0 || d !== 8'h00) begin
            miscompares++; $display("FAIL flush: cnt=%0d hist=%h expected 0 00", hist_count, d);
        end
    endtask

    task automatic test_reset_mid_write();
        do_fetch(8'h5A);
        do_write(3'd0, 8'h09);
        @(negedge clk); io_violation = 1'b1;
        @(negedge clk); io_violation = 1'b0;
        reg_cs = 1'b1; reg_sel = 3'd2; data_in = 8'h0C; wr_n = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        #1;
        vectors++;
        if (ctrl_out !== 16'h0 || hist_count !== 3'd0 || trap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: ctrl=%h cnt=%0d trap=%b expected 0", ctrl_out, hist_count, trap_pending);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk); wr_n = 1'b1;
        @(negedge clk); reg_cs = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ctrl_out, hist_count, trap_pending, data_oe} !== 21'h0) begin
            miscompares++;
            $display("FAIL rst_abort_write: ctrl=%h cnt=%0d trap=%b oe=%b expected all 0",
                     ctrl_out, hist_count, trap_pending, data_oe);
        end
        do_write(3'd2, 8'h0C);
        vectors++;
        if (ctrl_out !== 16'h0C00) begin
            miscompares++; $display("FAIL rst_recover: got %h expected 0C00", ctrl_out);
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_write();
        test_unmapped();
        test_fetch_fifo();
        test_overflow();
        test_push_pop_same_clk();
        test_violation();
        test_flush();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
